secuenciador_escritura: RTL
===========================

SECUENCIADOR_ESCRITURA -- requirements
Module: secuenciador_escritura

Interface
REQ-001 The module SHALL have these ports (clock and reset first): clk  in  1  single clock, all logic on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 EN  in  1  clock enable; when 0, all state, counters and outputs SHALL hold (done, err held at 0).
REQ-004 start  in  1  begin a write burst (sampled in IDLE only).
REQ-005 cancel  in  1  abort a burst; takes priority over every input except rst.
REQ-006 first_addr, last_addr  in  6 each  inclusive burst bounds, legal range 0..50.
REQ-007 din  in  8  data for the current address; din_valid in 1 / din_ready out 1  valid-ready handshake.
REQ-008 wr_addr  out  6  and wr_data  out  8  registered write address/data, stable while wr_req=1.
REQ-009 wr_req  out  1  write request; wr_ack  in  1  one-cycle write acknowledge.
REQ-010 busy  out  1  high outside IDLE; done  out  1  one-cycle burst-complete pulse; err  out  1  one-cycle error pulse.

Function
REQ-011 States SHALL be IDLE, LOAD, WRITE; only IDLE may accept start.
REQ-012 IDLE: start=1 with both bounds <=50 SHALL load pointer=first_addr and enter LOAD next cycle.
REQ-013 IDLE: start=1 with either bound >50 SHALL pulse err next cycle and remain IDLE.
REQ-014 LOAD: din_ready=1; din_valid=1 SHALL register wr_addr=pointer, wr_data=din, set wr_req=1 and enter WRITE next cycle.
REQ-015 WRITE: din_ready=0; wr_req, wr_addr, wr_data SHALL hold until wr_ack=1.
REQ-016 wr_ack=1 in WRITE with pointer==last_addr (as latched at start) SHALL clear wr_req, pulse done and enter IDLE next cycle.
REQ-017 wr_ack=1 in WRITE otherwise SHALL clear wr_req, advance pointer and enter LOAD next cycle.
REQ-018 Pointer advance SHALL be +1 modulo 51: 50 -> 0; first_addr>last_addr SHALL therefore burst 50->0 wrap-around.
REQ-019 first_addr==last_addr SHALL produce exactly one write.
REQ-020 wr_ack outside WRITE and start outside IDLE SHALL be ignored.
REQ-021 cancel=1 in LOAD or WRITE SHALL clear wr_req, din_ready, busy and enter IDLE next cycle without done; in IDLE it has no effect.
REQ-022 first_addr/last_addr changes after start SHALL not affect the running burst (latched at start).
REQ-023 Per address, total latency SHALL be: start->din_ready 1 cycle; handshake->wr_req 1 cycle; wr_ack->next din_ready or done 1 cycle.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, pointer=0, wr_addr=0, wr_data=0, wr_req=0, din_ready=0, busy=0, done=0, err=0, independent of clk and EN.
REQ-025 Reset mid-burst SHALL discard the burst; no done or err SHALL follow reset release.

Configuration
REQ-026 Macro SECUENCIADOR_TIMEOUT_EN, when defined, SHALL add an 8-bit watchdog counting WRITE cycles while wr_ack=0 (cleared on WRITE entry).
REQ-027 With the macro, 255 consecutive un-acked WRITE cycles SHALL clear wr_req, pulse err and enter IDLE; without it, WRITE SHALL wait indefinitely.
REQ-028 Watchdog SHALL freeze while EN=0.

Structure
REQ-029 Package secuenciador_pkg SHALL hold ADDR_W=6, DATA_W=8, ADDR_MAX=50, TIMEOUT_CYCLES=255 and the state enum.
REQ-030 The modulo-51 pointer SHALL be a sub-module puntero_escritura (load, increment, enable ports).

Verification
REQ-031 first=3,last=5, start, din 0xA1/0xA2/0xA3, ack 2 cycles after each wr_req -> writes (3,A1),(4,A2),(5,A3), then done 1 cycle, busy 0.
REQ-032 first=49,last=1 -> write addresses 49,50,0,1 in order, single done.
REQ-033 first=51 start -> err pulse, busy stays 0, no wr_req.
REQ-034 cancel during WRITE at addr 4 -> wr_req 0 next cycle, IDLE, no done; later start works normally.
REQ-035 EN=0 for 5 cycles mid-WRITE and async rst=0 mid-LOAD -> all outputs frozen during EN=0; all outputs 0 immediately on rst.
REQ-036 With SECUENCIADOR_TIMEOUT_EN, withhold wr_ack -> err pulse after 255 WRITE cycles, IDLE; without macro, wr_req stays 1 past 300 cycles.

Source files
------------

// File: rtl/secuenciador_escritura_pkg.sv
// Shared types and constants for the write sequencer (package secuenciador_pkg).
// Address space is 0..ADDR_MAX inclusive; the burst pointer wraps modulo ADDR_MAX+1.
package secuenciador_pkg;

    localparam int ADDR_W         = 6;
    localparam int DATA_W         = 8;
    localparam int ADDR_MAX       = 50;
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // True when an address lies inside the legal window.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a <= ADDR_W'(ADDR_MAX));
    endfunction

    // Next burst address: +1 with wrap from ADDR_MAX back to 0.
    function automatic logic [ADDR_W-1:0] addr_next(input logic [ADDR_W-1:0] a);
        return (a >= ADDR_W'(ADDR_MAX)) ? '0 : (a + ADDR_W'(1));
    endfunction

endpackage

// File: rtl/secuenciador_escritura_if.sv
// Bundle of control, data-input handshake and write-port signals of the sequencer.
// master: the environment driving the sequencer; slave: the sequencer itself.
interface secuenciador_escritura_if;
    import secuenciador_pkg::*;

    logic              EN;
    logic              start;
    logic              cancel;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              din_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_req;
    logic              wr_ack;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output EN, start, cancel, first_addr, last_addr, din, din_valid, wr_ack,
        input  din_ready, wr_addr, wr_data, wr_req, busy, done, err
    );

    modport slave (
        input  EN, start, cancel, first_addr, last_addr, din, din_valid, wr_ack,
        output din_ready, wr_addr, wr_data, wr_req, busy, done, err
    );

endinterface

// File: rtl/secuenciador_escritura_puntero.sv
// Burst address pointer (module puntero_escritura): loadable, increments modulo ADDR_MAX+1.
// Load has priority over increment; nothing moves while en_i is low.
module puntero_escritura
    import secuenciador_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] ptr_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Next pointer value: load, wrap-increment or hold.
    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            if (load_i) begin
                ptr_d = load_val_i;
            end else if (inc_i) begin
                ptr_d = addr_next(ptr_q);
            end
        end
    end

    // Pointer register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/secuenciador_escritura.sv
// Write-burst sequencer: walks addresses first_addr..last_addr (mod ADDR_MAX+1),
// taking one byte per address over a valid/ready input and issuing a held write
// request per address until acknowledged.
// Optional feature: define SECUENCIADOR_TIMEOUT_EN to add a watchdog that aborts a
// WRITE after TIMEOUT_CYCLES un-acknowledged cycles with an err pulse.
module secuenciador_escritura
    import secuenciador_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    secuenciador_escritura_if.slave     bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_req_q, wr_req_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              ptr_load, ptr_inc;
    logic [ADDR_W-1:0] ptr;
    logic              bounds_ok;
    logic              at_last;
    logic              timeout;

    assign bounds_ok = addr_ok(bus.first_addr) && addr_ok(bus.last_addr);
    assign at_last   = (ptr == last_q);

`ifdef SECUENCIADOR_TIMEOUT_EN
    logic [7:0] wdog_q;

    // Watchdog: counts un-acked WRITE cycles, zero whenever not in WRITE, frozen by EN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_q <= '0;
        end else if (bus.EN) begin
            if (state_q != WRITE) begin
                wdog_q <= '0;
            end else if (!bus.wr_ack) begin
                wdog_q <= wdog_q + 8'd1;
            end
        end
    end

    assign timeout = (state_q == WRITE) && (wdog_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    puntero_escritura u_puntero (
        .clk        (clk),
        .rst        (rst),
        .en_i       (bus.EN),
        .load_i     (ptr_load),
        .inc_i      (ptr_inc),
        .load_val_i (bus.first_addr),
        .ptr_o      (ptr)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cancel outranks handshake, ack and timeout outside IDLE.
    always_comb begin
        state_d = state_q;
        if (bus.EN) begin
            case (state_q)
                IDLE: begin
                    if (bus.start && bounds_ok) state_d = LOAD;
                end
                LOAD: begin
                    if (bus.cancel)         state_d = IDLE;
                    else if (bus.din_valid) state_d = WRITE;
                end
                WRITE: begin
                    if (bus.cancel)      state_d = IDLE;
                    else if (bus.wr_ack) state_d = at_last ? IDLE : LOAD;
                    else if (timeout)    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/datapath next values; pulses default low, everything else holds.
    always_comb begin
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_req_d  = wr_req_q;
        last_d    = last_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        if (bus.EN) begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bounds_ok) begin
                            ptr_load = 1'b1;
                            last_d   = bus.last_addr;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (!bus.cancel && bus.din_valid) begin
                        wr_addr_d = ptr;
                        wr_data_d = bus.din;
                        wr_req_d  = 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.cancel) begin
                        wr_req_d = 1'b0;
                    end else if (bus.wr_ack) begin
                        wr_req_d = 1'b0;
                        if (at_last) done_d  = 1'b1;
                        else         ptr_inc = 1'b1;
                    end else if (timeout) begin
                        wr_req_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end
                default: wr_req_d = 1'b0;
            endcase
        end
    end

    // Output and latched-bound registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_req_q  <= 1'b0;
            last_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_req_q  <= wr_req_d;
            last_q    <= last_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.din_ready = (state_q == LOAD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_req    = wr_req_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
